// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   - default parameter values for data width, requester count, busy-wait limit
//   - 3-bit FSM state encoding used by uart_tx_arbiter
package uart_pkg;

  localparam int DEF_DATA_LENGTH = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_WAIT_LIMIT  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_LAUNCH    = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search.
// Ports:
//   req          in  : request vector, one bit per requester
//   ptr          in  : index where the search starts (highest priority)
//   grant_onehot out : one-hot winner, zero when nothing is requested
//   grant_idx    out : binary index of the winner, zero when nothing is requested
//   any_req      out : at least one request bit is set
module rr_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  // Each requester's priority is its circular distance from ptr; the
  // requesting entry with the smallest distance wins.
  always_comb begin
    int w_dist;
    int w_best;
    w_dist    = 0;
    w_best    = NUM_REQ;
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (req[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        grant_idx = IDX_W'(i);
      end
    end
    any_req = |req;
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = any_req && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART TX core among NUM_REQ requesters.
// Ports:
//   CLK, RST       : clock, asynchronous active-high reset
//   req_valid      : per-requester request, held until acked
//   req_data       : packed bytes, requester i at [i*DATA_LENGTH +: DATA_LENGTH]
//   req_par_en     : per-requester parity enable
//   req_ack        : one-cycle one-hot pulse when a byte is captured
//   tx_busy        : busy flag from the UART TX core
//   tx_data_valid  : one-cycle launch strobe to the UART TX core
//   tx_p_data      : byte to the UART TX core, held until the next grant
//   tx_par_en      : parity enable to the UART TX core, held like tx_p_data
//   grant_id       : index of the current or last granted requester
//   arb_busy       : high whenever the FSM is not idle
//   tx_timeout     : sticky flag, core never raised tx_busy after a launch
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no frame in flight; waits for a request while core is idle
// ST_GRANT     | pick winner, capture its byte, pulse its ack
// ST_LAUNCH    | tx_data_valid high for this single cycle
// ST_WAIT_BUSY | wait up to WAIT_LIMIT cycles for the core to go busy
// ST_WAIT_DONE | core is transmitting; wait for tx_busy to fall
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int DATA_LENGTH = DEF_DATA_LENGTH,
  parameter  int NUM_REQ     = DEF_NUM_REQ,
  parameter  int WAIT_LIMIT  = DEF_WAIT_LIMIT,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int WCNT_W      = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]             req_par_en,
  output logic [NUM_REQ-1:0]             req_ack,
  input  logic                           tx_busy,
  output logic                           tx_data_valid,
  output logic [DATA_LENGTH-1:0]         tx_p_data,
  output logic                           tx_par_en,
  output logic [IDX_W-1:0]               grant_id,
  output logic                           arb_busy,
  output logic                           tx_timeout
);

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [IDX_W-1:0]       r_rr_ptr;
  logic [IDX_W-1:0]       r_grant_id;
  logic [DATA_LENGTH-1:0] r_p_data;
  logic                   r_par_en;
  logic                   r_timeout;
  logic [WCNT_W-1:0]      r_wait_cnt;

  logic [NUM_REQ-1:0]     w_grant_onehot;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_any_req;
  logic                   w_grant;
  logic                   w_timeout_hit;
  logic [DATA_LENGTH-1:0] w_sel_data;
  logic                   w_sel_par;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req          (req_valid),
    .ptr          (r_rr_ptr),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any_req      (w_any_req)
  );

  assign w_grant       = (r_state == ST_GRANT) && w_any_req;
  assign w_timeout_hit = (r_state == ST_WAIT_BUSY) && !tx_busy && (r_wait_cnt == '0);

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_onehot[i]) w_sel_data = req_data[i*DATA_LENGTH +: DATA_LENGTH];
    end
    w_sel_par = |(req_par_en & w_grant_onehot);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:      if (|req_valid && !tx_busy) w_state_nxt = ST_GRANT;
      // A requester may withdraw between IDLE and GRANT; with nobody left
      // there is nothing to launch, so fall back to IDLE without an ack.
      ST_GRANT:     w_state_nxt = w_any_req ? ST_LAUNCH : ST_IDLE;
      ST_LAUNCH:    w_state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (tx_busy)            w_state_nxt = ST_WAIT_DONE;
        else if (w_timeout_hit) w_state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (!tx_busy) w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_p_data   <= '0;
      r_par_en   <= 1'b0;
      r_timeout  <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_p_data   <= w_sel_data;
        r_par_en   <= w_sel_par;
        r_grant_id <= w_grant_idx;
        r_rr_ptr   <= (w_grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
      end
      // Down-counter loaded on the way into WAIT_BUSY; terminal count 0
      // together with tx_busy still low marks the WAIT_LIMIT-th cycle.
      if (r_state == ST_LAUNCH)
        r_wait_cnt <= WCNT_W'(WAIT_LIMIT-1);
      else if ((r_state == ST_WAIT_BUSY) && (r_wait_cnt != '0))
        r_wait_cnt <= r_wait_cnt - 1'b1;
      if (w_timeout_hit) r_timeout <= 1'b1;
    end
  end

  assign req_ack       = w_grant ? w_grant_onehot : '0;
  assign tx_data_valid = (r_state == ST_LAUNCH);
  assign arb_busy      = (r_state != ST_IDLE);
  assign tx_p_data     = r_p_data;
  assign tx_par_en     = r_par_en;
  assign grant_id      = r_grant_id;
  assign tx_timeout    = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a bench-side UART TX model.
module tb_uart_tx_arbiter;

  localparam int DL       = 8;
  localparam int NR       = 4;
  localparam int WL       = 4;
  localparam int IW       = 2;
  localparam int BUSY_LEN = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DL-1:0]  req_data;
  logic [NR-1:0]     req_par_en;
  logic [NR-1:0]     req_ack;
  logic              tx_busy;
  logic              tx_data_valid;
  logic [DL-1:0]     tx_p_data;
  logic              tx_par_en;
  logic [IW-1:0]     grant_id;
  logic              arb_busy;
  logic              tx_timeout;

  uart_tx_arbiter #(.DATA_LENGTH(DL), .NUM_REQ(NR), .WAIT_LIMIT(WL)) dut (
    .CLK(clk), .RST(rst), .req_valid(req_valid), .req_data(req_data),
    .req_par_en(req_par_en), .req_ack(req_ack), .tx_busy(tx_busy),
    .tx_data_valid(tx_data_valid), .tx_p_data(tx_p_data), .tx_par_en(tx_par_en),
    .grant_id(grant_id), .arb_busy(arb_busy), .tx_timeout(tx_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // values seen at the last negedge sample
  logic [NR-1:0] s_ack;
  logic          s_dv, s_par, s_arb, s_to, s_busy;
  logic [DL-1:0] s_data;
  logic [IW-1:0] s_id;

  // behavioural model: frame timeline relative to an observed grant
  int            m_ptr, m_id, m_stage, m_wc;
  logic [DL-1:0] m_data;
  logic          m_par, m_to, m_can_grant, m_dv_due;

  // UART TX core model
  int busy_cnt, start_cnt, uart_delay;
  bit uart_never;

  int glog[$];
  int gcyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_check();
    int win;
    logic [NR-1:0] exp_ack;
    logic exp_arb;
    if (rst) begin
      chk("rst req_ack", req_ack, 0);
      chk("rst tx_data_valid", tx_data_valid, 0);
      chk("rst tx_p_data", tx_p_data, 0);
      chk("rst tx_par_en", tx_par_en, 0);
      chk("rst grant_id", grant_id, 0);
      chk("rst arb_busy", arb_busy, 0);
      chk("rst tx_timeout", tx_timeout, 0);
      m_ptr = 0; m_id = 0; m_data = '0; m_par = 0; m_to = 0;
      m_stage = 0; m_wc = 0; m_can_grant = 0; m_dv_due = 0;
    end else begin
      win = -1;
      if (m_can_grant) begin
        for (int k = 0; k < NR; k++) begin
          int j;
          j = (m_ptr + k) % NR;
          if (win < 0 && ((req_valid >> j) & 4'd1) != 0) win = j;
        end
      end
      exp_ack = (win >= 0) ? NR'(1 << win) : '0;
      exp_arb = m_can_grant || (m_stage != 0);
      chk("req_ack", req_ack, exp_ack);
      chk("tx_data_valid", tx_data_valid, m_dv_due);
      chk("tx_p_data", tx_p_data, m_data);
      chk("tx_par_en", tx_par_en, m_par);
      chk("grant_id", grant_id, m_id);
      chk("tx_timeout", tx_timeout, m_to);
      chk("arb_busy", arb_busy, exp_arb);
      for (int i = 0; i < NR; i++) if (req_ack[i]) begin glog.push_back(i); gcyc.push_back(cyc); end
      m_dv_due = (win >= 0);
      case (m_stage)
        1: begin m_stage = 2; m_wc = 0; end
        2: begin
          if (tx_busy) m_stage = 3;
          else begin
            m_wc++;
            if (m_wc == WL) begin m_to = 1; m_stage = 0; end
          end
        end
        3: if (!tx_busy) m_stage = 0;
        default: ;
      endcase
      if (win >= 0) begin
        m_stage = 1;
        m_data  = DL'(req_data >> (win*DL));
        m_par   = ((req_par_en >> win) & 4'd1) != 0;
        m_id    = win;
        m_ptr   = (win + 1) % NR;
      end
      m_can_grant = !exp_arb && (req_valid != 0) && !tx_busy;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    s_ack = req_ack; s_dv = tx_data_valid; s_data = tx_p_data; s_par = tx_par_en;
    s_id = grant_id; s_arb = arb_busy; s_to = tx_timeout; s_busy = tx_busy;
    model_check();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~s_ack;
    if (busy_cnt > 0) busy_cnt--;
    if (start_cnt > 0) begin
      start_cnt--;
      if (start_cnt == 0) busy_cnt = BUSY_LEN;
    end
    if (s_dv && !uart_never) begin
      if (uart_delay == 0) busy_cnt = BUSY_LEN;
      else start_cnt = uart_delay;
    end
    tx_busy = (busy_cnt > 0);
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    do begin step(); n++; end while (s_ack == 0 && n < 60);
    chk({name, " ack seen"}, (s_ack != 0), 1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin step(); n++; end while (s_arb != 0 && n < 60);
    chk({name, " back to idle"}, s_arb, 0);
  endtask

  task automatic wait_grants(input string name, input int target);
    int n;
    n = 0;
    while (glog.size() < target && n < 300) begin step(); n++; end
    chk({name, " grant count"}, glog.size(), target);
  endtask

  initial begin
    int base;
    rst = 1; req_valid = '0; tx_busy = 0;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};
    req_par_en = 4'b0100;
    busy_cnt = 0; start_cnt = 0; uart_delay = 0; uart_never = 0;
    m_ptr = 0; m_id = 0; m_stage = 0; m_wc = 0; m_data = '0;
    m_par = 0; m_to = 0; m_can_grant = 0; m_dv_due = 0;
    repeat (3) step();
    rst = 0;
    repeat (2) step();

    // single request from requester 2
    req_valid = 4'b0100;
    wait_ack("single");
    chk("single req_ack", s_ack, 4'b0100);
    step();
    chk("single dv", s_dv, 1);
    chk("single data", s_data, 8'hA5);
    chk("single par", s_par, 1);
    chk("single grant_id", s_id, 2);
    step();
    chk("single ack one cycle", s_ack, 0);
    wait_idle("single");

    // all four requesting from rr_ptr=0
    rst = 1; step(); rst = 0; step();
    base = glog.size();
    req_valid = 4'b1111;
    wait_grants("all four", base + 4);
    if (glog.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk($sformatf("all four order %0d", k), glog[base+k], k);
      for (int k = 1; k < 4; k++) chk($sformatf("all four spacing %0d", k), gcyc[base+k] - gcyc[base+k-1], 14);
    end
    wait_idle("all four");

    // 3 just served: 0 must come before 3 again
    base = glog.size();
    req_valid = 4'b1001;
    wait_grants("after 3", base + 2);
    if (glog.size() >= base + 2) begin
      chk("after 3 first", glog[base], 0);
      chk("after 3 second", glog[base+1], 3);
    end
    wait_idle("after 3");

    // requester 1 withdraws during requester 0's frame
    req_valid = 4'b0111;
    wait_ack("withdraw first");
    chk("withdraw first ack", s_ack, 4'b0001);
    repeat (4) step();
    req_valid[1] = 1'b0;
    wait_ack("withdraw next");
    chk("withdraw skips 1", s_ack, 4'b0100);
    wait_idle("withdraw");
    chk("withdraw no pending", req_valid, 0);

    // busy rises on the last allowed waiting cycle: no timeout
    uart_delay = 3;
    req_valid = 4'b1000;
    wait_ack("late busy");
    chk("late busy ack", s_ack, 4'b1000);
    wait_idle("late busy");
    chk("late busy no timeout", s_to, 0);
    uart_delay = 0;

    // reset while waiting for the frame to finish
    req_valid = 4'b0010;
    wait_ack("mid reset");
    chk("mid reset ack", s_ack, 4'b0010);
    repeat (4) step();
    chk("mid reset in frame", s_arb, 1);
    req_valid = 4'b1000;
    rst = 1;
    step();
    chk("mid reset ack low", s_ack, 0);
    chk("mid reset arb low", s_arb, 0);
    chk("mid reset data", s_data, 0);
    chk("mid reset core still busy", s_busy, 1);
    step();
    rst = 0;
    req_valid = 4'b1001;
    wait_ack("after reset");
    chk("after reset ptr 0", s_ack, 4'b0001);
    wait_ack("after reset second");
    chk("after reset second ack", s_ack, 4'b1000);
    wait_idle("after reset");

    // core never goes busy
    uart_never = 1;
    req_valid = 4'b0100;
    wait_ack("timeout");
    step();
    chk("timeout launch", s_dv, 1);
    repeat (4) step();
    chk("timeout not yet", s_to, 0);
    chk("timeout still busy", s_arb, 1);
    step();
    chk("timeout set", s_to, 1);
    chk("timeout idle", s_arb, 0);
    for (int k = 0; k < 3; k++) begin
      req_valid = NR'(1 << k);
      wait_ack($sformatf("timeout extra %0d", k));
      wait_idle($sformatf("timeout extra %0d", k));
    end
    uart_never = 0;
    req_valid = 4'b1000;
    wait_ack("timeout normal");
    wait_idle("timeout normal");
    chk("timeout sticky", s_to, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 8, giving the width of each data byte.
REQ-002 SHALL have parameter NUM_REQ, default 4, giving the number of requesters (range 2..8).
REQ-003 SHALL have parameter WAIT_LIMIT, default 4, giving the maximum cycles to wait for tx_busy to rise.
REQ-004 SHALL have port CLK, input, width 1: the single clock; all logic rises on its posedge.
REQ-005 SHALL have port RST, input, width 1: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, width NUM_REQ: per-requester request, held until acked.
REQ-007 SHALL have port req_data, input, width NUM_REQ*DATA_LENGTH: requester i's byte in slice [i*DATA_LENGTH +: DATA_LENGTH].
REQ-008 SHALL have port req_par_en, input, width NUM_REQ: per-requester parity enable.
REQ-009 SHALL have port req_ack, output, width NUM_REQ: one-cycle one-hot pulse when a byte is captured.
REQ-010 SHALL have port tx_busy, input, width 1: busy flag from the UART TX core.
REQ-011 SHALL have port tx_data_valid, output, width 1: Data_valid to the UART TX core.
REQ-012 SHALL have port tx_p_data, output, width DATA_LENGTH: parallel byte to the UART TX core.
REQ-013 SHALL have port tx_par_en, output, width 1: Par_en to the UART TX core.
REQ-014 SHALL have port grant_id, output, width $clog2(NUM_REQ): index of the current or last granted requester.
REQ-015 SHALL have port arb_busy, output, width 1: high in every state except IDLE.
REQ-016 SHALL have port tx_timeout, output, width 1: sticky error flag.

Function
REQ-017 SHALL implement an FSM with states IDLE, GRANT, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-018 SHALL move from IDLE to GRANT in the cycle after any req_valid bit is high while tx_busy=0.
REQ-019 In GRANT, SHALL select the winner round-robin, starting the search at rr_ptr and wrapping NUM_REQ-1 to 0.
REQ-020 In GRANT, SHALL register the winner's req_data and req_par_en into tx_p_data and tx_par_en, update grant_id, and pulse req_ack[winner] for one cycle.
REQ-021 After each grant, SHALL set rr_ptr to (winner+1) mod NUM_REQ.
REQ-022 SHALL move GRANT to LAUNCH unconditionally.
REQ-023 In LAUNCH, SHALL hold tx_data_valid=1 for exactly one cycle, then move to WAIT_BUSY.
REQ-024 In WAIT_BUSY, SHALL move to WAIT_DONE on tx_busy=1; the wait counter resets on entry.
REQ-025 If tx_busy stays 0 for WAIT_LIMIT cycles in WAIT_BUSY, SHALL set tx_timeout=1 and return to IDLE.
REQ-026 In WAIT_DONE, SHALL return to IDLE on tx_busy=0; the next grant therefore happens no earlier than 2 cycles after tx_busy falls.
REQ-027 SHALL hold tx_p_data and tx_par_en stable from GRANT until the next GRANT.
REQ-028 If req_valid[i] drops before it is granted, SHALL treat requester i as not requesting, with no ack.
REQ-029 When requests are simultaneous, SHALL grant exactly one per frame, by round-robin order only.
REQ-030 SHALL keep tx_timeout set until reset, independent of further traffic.
REQ-031 SHALL ignore tx_busy in IDLE except as a gate: no grant while tx_busy=1.

Reset
REQ-032 On RST=1, asynchronously: state=IDLE, rr_ptr=0, grant_id=0, tx_p_data=0, tx_par_en=0, tx_data_valid=0, req_ack=0, arb_busy=0, tx_timeout=0, wait counter=0.
REQ-033 On reset asserted mid-frame, SHALL abort silently, issue no ack, and leave the UART core to finish its frame.
REQ-034 After RST deasserts, SHALL start normal operation on the first clock edge.

Structure
REQ-035 SHALL place the FSM state encodings (3-bit) and the default parameter values in a shared package uart_pkg.
REQ-036 SHALL implement the winner search as one sub-module, rr_arbiter (inputs req and ptr; outputs grant_onehot, grant_idx and any_req), which is purely combinational.
REQ-037 SHALL allow the FSM, registers and counter to reside in uart_tx_arbiter itself.

Verification
REQ-038 Single request: req_valid=4'b0100, byte 8'hA5, par_en=1 -> req_ack=4'b0100 one cycle, tx_data_valid pulse 1 cycle later with tx_p_data=8'hA5, tx_par_en=1, grant_id=2.
REQ-039 All four requesting, rr_ptr=0, UART model busy 10 cycles per frame -> grant order 0,1,2,3, each ack only after the previous tx_busy fall.
REQ-040 Requests 4'b1001 after requester 3 was just served -> requester 0 granted next; requester 3 is not re-granted before 0.
REQ-041 UART model never raises tx_busy -> after LAUNCH plus 4 cycles, tx_timeout=1, state IDLE, flag still 1 after 3 further frames.
REQ-042 RST pulsed during WAIT_DONE -> all outputs at reset values in the same cycle, rr_ptr=0, no req_ack emitted.
REQ-043 Requester 1 drops req_valid during another requester's frame -> no ack to requester 1, and it is skipped at the next GRANT.
